// File: rtl/mmio_output_peripherals.sv
// Memory-mapped N-channel output port with static/blink/PWM modes; OUTPUT_PWM_EN enables PWM.
// Latency: store reaches pins 2 edges after strobe; read_data valid 1 cycle after read_enable.
// Backpressure: none, single-cycle strobes are always accepted.
module mmio_output_peripherals #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int PWM_BITS     = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    write_enable,
    input  logic                    read_enable,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   write_data,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic [NUM_CHANNELS-1:0] output_peripherals
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_OUT    = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MODE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_PRESC  = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = ADDR_WIDTH'(3);

    logic [NUM_CHANNELS-1:0]   out_data_q, out_data_d;
    logic [2*NUM_CHANNELS-1:0] mode_q, mode_d;
    logic [DATA_WIDTH-1:0]     prescale_q, prescale_d;
    logic [DATA_WIDTH-1:0]     presc_cnt_q, presc_cnt_d;
    logic                      blink_phase_q, blink_phase_d;
    logic [DATA_WIDTH-1:0]     read_data_q, read_data_d;
    logic [NUM_CHANNELS-1:0]   out_q, out_d;
    logic [DATA_WIDTH-1:0]     rd_val;
    logic                      tick;
    logic                      wr_out, wr_mode, wr_presc;

`ifdef OUTPUT_PWM_EN
    logic [PWM_BITS-1:0]       pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0]       duty_q [NUM_CHANNELS];
`endif

    assign wr_out   = write_enable && (address == ADDR_OUT);
    assign wr_mode  = write_enable && (address == ADDR_MODE);
    assign wr_presc = write_enable && (address == ADDR_PRESC);

    // A PRESCALE store restarts the period; a tick coinciding with it still fires.
    always_comb begin
        tick          = (presc_cnt_q == '0);
        out_data_d    = wr_out   ? write_data[NUM_CHANNELS-1:0]   : out_data_q;
        mode_d        = wr_mode  ? write_data[2*NUM_CHANNELS-1:0] : mode_q;
        prescale_d    = wr_presc ? write_data                      : prescale_q;
        blink_phase_d = blink_phase_q ^ tick;
        if (wr_presc) begin
            presc_cnt_d = write_data;
        end else if (tick) begin
            presc_cnt_d = prescale_q;
        end else begin
            presc_cnt_d = presc_cnt_q - 1'b1;
        end
`ifdef OUTPUT_PWM_EN
        pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
`endif
    end

    always_comb begin
        out_d = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            case (mode_q[2*ch +: 2])
                2'b01:   out_d[ch] = out_data_q[ch] & blink_phase_q;
`ifdef OUTPUT_PWM_EN
                2'b10:   out_d[ch] = out_data_q[ch] & (pwm_cnt_q < duty_q[ch]);
`endif
                default: out_d[ch] = out_data_q[ch];
            endcase
        end
    end

    // Read mux sees pre-edge state, so a same-cycle read+write returns the old value.
    always_comb begin
        rd_val = '0;
        case (address)
            ADDR_OUT:    rd_val[NUM_CHANNELS-1:0]   = out_data_q;
            ADDR_MODE:   rd_val[2*NUM_CHANNELS-1:0] = mode_q;
            ADDR_PRESC:  rd_val                     = prescale_q;
            ADDR_STATUS: begin
                rd_val[0] = blink_phase_q;
`ifdef OUTPUT_PWM_EN
                rd_val[PWM_BITS:1] = pwm_cnt_q;
`endif
            end
            default: begin
`ifdef OUTPUT_PWM_EN
                for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                    if (address == ADDR_WIDTH'(4 + ch)) begin
                        rd_val[PWM_BITS-1:0] = duty_q[ch];
                    end
                end
`endif
            end
        endcase
        read_data_d = read_enable ? rd_val : read_data_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_data_q    <= '0;
            mode_q        <= '0;
            prescale_q    <= '0;
            presc_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            read_data_q   <= '0;
            out_q         <= '0;
        end else begin
            out_data_q    <= out_data_d;
            mode_q        <= mode_d;
            prescale_q    <= prescale_d;
            presc_cnt_q   <= presc_cnt_d;
            blink_phase_q <= blink_phase_d;
            read_data_q   <= read_data_d;
            out_q         <= out_d;
        end
    end

`ifdef OUTPUT_PWM_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt_q <= '0;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                duty_q[ch] <= '0;
            end
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                if (write_enable && (address == ADDR_WIDTH'(4 + ch))) begin
                    duty_q[ch] <= write_data[PWM_BITS-1:0];
                end
            end
        end
    end
`endif

    assign read_data          = read_data_q;
    assign output_peripherals = out_q;

endmodule

// File: tb/tb_mmio_output_peripherals.sv
// Directed bench for mmio_output_peripherals: reset, readback, blink, PWM, prescale restart, mid-op reset.
module tb_mmio_output_peripherals;

    logic        clock;
    logic        reset_n;
    logic        write_enable;
    logic        read_enable;
    logic [4:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [3:0]  output_peripherals;

    int n_cmp = 0;
    int n_err = 0;

    mmio_output_peripherals dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .write_enable       (write_enable),
        .read_enable        (read_enable),
        .address            (address),
        .write_data         (write_data),
        .read_data          (read_data),
        .output_peripherals (output_peripherals)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        address      = a;
        write_data   = d;
        write_enable = 1'b1;
        step(1);
        write_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        address     = a;
        read_enable = 1'b1;
        step(1);
        read_enable = 1'b0;
        d           = read_data;
    endtask

    task automatic do_reset();
        #2;
        reset_n      = 1'b0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        step(2);
        reset_n = 1'b1;
    endtask

    task automatic count_ch1(output int n);
        n = 0;
        repeat (256) begin
            step(1);
            n += int'(output_peripherals[1]);
        end
    endtask

    logic [31:0] rd;
    int          cnt;

    initial begin
        reset_n      = 1'b0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        address      = '0;
        write_data   = '0;

        // 1: reset holds everything at zero despite bus traffic
        for (int i = 0; i < 8; i++) begin
            write_enable = 1'($urandom);
            read_enable  = 1'($urandom);
            address      = 5'($urandom);
            write_data   = $urandom;
            step(1);
            chk("rst_out", 32'(output_peripherals), 32'h0);
            chk("rst_rd", read_data, 32'h0);
        end
        write_enable = 1'b0;
        read_enable  = 1'b0;
        reset_n      = 1'b1;
        bus_write(5'd0, 32'h8);
        chk("t1_one_edge", 32'(output_peripherals), 32'h0);
        step(1);
        chk("t1_two_edges", 32'(output_peripherals), 32'h8);

        // 2: readback, unmapped, read-during-write, hold, dropped bits, mode 11
        bus_write(5'd1, 32'h5);
        bus_write(5'd2, 32'h7);
        bus_read(5'd1, rd);  chk("t2_mode", rd, 32'h5);
        bus_read(5'd2, rd);  chk("t2_presc", rd, 32'h7);
        bus_read(5'd31, rd); chk("t2_unmapped", rd, 32'h0);
        address      = 5'd0;
        write_data   = 32'h3;
        write_enable = 1'b1;
        read_enable  = 1'b1;
        step(1);
        write_enable = 1'b0;
        read_enable  = 1'b0;
        chk("t2_rw_old", read_data, 32'h8);
        bus_read(5'd0, rd);  chk("t2_rw_new", rd, 32'h3);
        step(3);
        chk("t2_hold", read_data, 32'h3);
        bus_write(5'd0, 32'hFFFF_FFF5);
        bus_read(5'd0, rd);  chk("t2_out_trunc", rd, 32'h5);
        bus_write(5'd1, 32'hFFFF_FFFF);
        bus_read(5'd1, rd);  chk("t2_mode_trunc", rd, 32'hFF);
        step(2);
        chk("t2_mode11", 32'(output_peripherals), 32'h5);

        // 3: blink with PRESCALE=3; ch0 toggles every 4 cycles
        do_reset();
        bus_write(5'd2, 32'd3);
        bus_write(5'd1, 32'h1);
        bus_write(5'd0, 32'h1);
        for (int k = 4; k <= 19; k++) begin
            step(1);
            chk("t3_blink", 32'(output_peripherals), ((((k - 2) / 4) % 2) == 0) ? 32'h1 : 32'h0);
        end
        bus_write(5'd0, 32'h0);
        for (int k = 0; k < 8; k++) begin
            step(1);
            chk("t3_cleared", 32'(output_peripherals), 32'h0);
        end

        // 4: STATUS fields, DUTY readback and PWM duty cycle counts
        do_reset();
        bus_read(5'd3, rd); chk("t4_status0", rd, 32'h0);
        bus_read(5'd3, rd);
`ifdef OUTPUT_PWM_EN
        chk("t4_status1", rd, 32'h3);
`else
        chk("t4_status1", rd, 32'h1);
`endif
        bus_write(5'd5, 32'd64);
        bus_read(5'd5, rd);
`ifdef OUTPUT_PWM_EN
        chk("t4_duty_rd", rd, 32'd64);
`else
        chk("t4_duty_rd", rd, 32'd0);
`endif
        bus_write(5'd1, 32'h8);
        bus_write(5'd0, 32'h2);
        step(2);
        count_ch1(cnt);
`ifdef OUTPUT_PWM_EN
        chk("t4_pwm64", 32'(cnt), 32'd64);
`else
        chk("t4_pwm64", 32'(cnt), 32'd256);
`endif
        bus_write(5'd5, 32'd0);
        step(2);
        count_ch1(cnt);
`ifdef OUTPUT_PWM_EN
        chk("t4_pwm0", 32'(cnt), 32'd0);
`else
        chk("t4_pwm0", 32'(cnt), 32'd256);
`endif
        bus_write(5'd5, 32'd255);
        step(2);
        count_ch1(cnt);
`ifdef OUTPUT_PWM_EN
        chk("t4_pwm255", 32'(cnt), 32'd255);
`else
        chk("t4_pwm255", 32'(cnt), 32'd256);
`endif

        // 5: PRESCALE rewrite mid-count; next tick 10 edges after the store
        do_reset();
        bus_write(5'd2, 32'd5);
        bus_write(5'd1, 32'h1);
        bus_write(5'd0, 32'h1);
        bus_write(5'd2, 32'd9);
        for (int k = 5; k <= 15; k++) begin
            step(1);
            chk("t5_restart", 32'(output_peripherals), (k <= 14) ? 32'h1 : 32'h0);
        end

        // 6: asynchronous reset while blinking
        step(10);
        chk("t6_pre", 32'(output_peripherals), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_out", 32'(output_peripherals), 32'h0);
        chk("t6_async_rd", read_data, 32'h0);
        step(1);
        reset_n = 1'b1;
        bus_write(5'd0, 32'h8);
        chk("t6_one_edge", 32'(output_peripherals), 32'h0);
        step(1);
        chk("t6_two_edges", 32'(output_peripherals), 32'h8);
        bus_read(5'd1, rd); chk("t6_mode_clr", rd, 32'h0);
        bus_read(5'd2, rd); chk("t6_presc_clr", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
